joy_serial_mp: RTL



---
 rtl/joy_serial_pkg.sv | 19 +
 rtl/joy_debounce.sv | 54 +++++
 rtl/joy_serial_mp.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/joy_serial_pkg.sv
// Shared types and helpers for the serial joystick chain reader.
package joy_serial_pkg;

  localparam int MAX_BITS = 128;

  typedef enum logic [1:0] {
    GAP   = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Clock cycles from one joy_load fall to the next with enable held high.
  function automatic int frame_cycles(input int players, input int bits,
                                      input int div, input int gap);
    return div * (gap + 1 + 2 * players * bits) + 1;
  endfunction

endpackage

// File: rtl/joy_debounce.sv
// Per-bit frame debouncer: an output bit follows raw only after DEBOUNCE
// consecutive strobed frames in which raw differed from it.
module joy_debounce #(
  parameter int WIDTH    = 32,
  parameter int DEBOUNCE = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             strobe,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] q,
  output logic             changed
);

  localparam logic [2:0] DEB_LAST = 3'(DEBOUNCE - 1);

  logic [WIDTH-1:0][2:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]      q_q, q_d;
  logic                  changed_q, changed_d;

  always_comb begin
    cnt_d = cnt_q;
    q_d   = q_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (strobe) begin
        if (raw[i] == q_q[i]) begin
          cnt_d[i] = 3'd0;
        end else if (cnt_q[i] == DEB_LAST) begin
          q_d[i]   = raw[i];
          cnt_d[i] = 3'd0;
        end else begin
          cnt_d[i] = cnt_q[i] + 3'd1;
        end
      end
    end
    changed_d = strobe && (q_d != q_q);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      q_q       <= '0;
      changed_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      q_q       <= q_d;
      changed_q <= changed_d;
    end
  end

  assign q       = q_q;
  assign changed = changed_q;

endmodule

// File: rtl/joy_serial_mp.sv
// Reader for daisy-chained 74HC165 joystick adapters: divider-paced
// GAP/LOAD/SHIFT/DONE sequencer feeding a per-bit frame debouncer.
module joy_serial_mp #(
  parameter int NUM_PLAYERS     = 2,
  parameter int BITS_PER_PLAYER = 16,
  parameter int CLK_DIV         = 64,
  parameter int GAP_TICKS       = 32,
  parameter int DEBOUNCE        = 2
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   enable,
  input  logic                                   joy_data,
  output logic                                   joy_clk,
  output logic                                   joy_load,
  output logic [NUM_PLAYERS*BITS_PER_PLAYER-1:0] joystick,
  output logic                                   valid,
  output logic                                   changed
);

  import joy_serial_pkg::*;

  localparam int N     = NUM_PLAYERS * BITS_PER_PLAYER;
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int GAP_W = $clog2(GAP_TICKS + 1);
  localparam int IDX_W = $clog2(N);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TICKS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             phase_q, phase_d;
  logic [N-1:0]     raw_q, raw_d;
  logic             joy_clk_q, joy_clk_d;
  logic             joy_load_q, joy_load_d;
  logic             valid_q, valid_d;
  logic             tick;

  assign tick = (div_q == DIV_LAST);

  // Divider pauses for the single DONE cycle so every frame is one cycle
  // longer than a whole number of ticks while keeping tick spacing exact.
  always_comb begin
    if (state_q == DONE) begin
      div_d = div_q;
    end else if (tick) begin
      div_d = '0;
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    idx_d   = idx_q;
    phase_d = phase_q;
    raw_d   = raw_q;
    unique case (state_q)
      GAP: begin
        if (tick) begin
          if (gap_q == GAP_LAST) begin
            gap_d = '0;
            if (enable) state_d = LOAD;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
      end
      LOAD: begin
        if (tick) begin
          state_d = SHIFT;
          idx_d   = '0;
          phase_d = 1'b0;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (!phase_q) begin
            raw_d[idx_q] = ~joy_data;
            phase_d      = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (idx_q == IDX_LAST) state_d = DONE;
            else                   idx_d   = idx_q + IDX_W'(1);
          end
        end
      end
      DONE:    state_d = GAP;
      default: state_d = GAP;
    endcase
    joy_load_d = (state_d != LOAD);
    joy_clk_d  = (state_d == SHIFT) && phase_d;
    valid_d    = (state_q == DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= GAP;
      div_q      <= '0;
      gap_q      <= '0;
      idx_q      <= '0;
      phase_q    <= 1'b0;
      joy_clk_q  <= 1'b0;
      joy_load_q <= 1'b1;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      gap_q      <= gap_d;
      idx_q      <= idx_d;
      phase_q    <= phase_d;
      joy_clk_q  <= joy_clk_d;
      joy_load_q <= joy_load_d;
      valid_q    <= valid_d;
    end
  end

  // Raw capture is fully rewritten by every frame before DONE, so it needs no reset.
  always_ff @(posedge clk) begin
    raw_q <= raw_d;
  end

  joy_debounce #(
    .WIDTH    (N),
    .DEBOUNCE (DEBOUNCE)
  ) u_debounce (
    .clk     (clk),
    .reset_n (reset_n),
    .strobe  (state_q == DONE),
    .raw     (raw_q),
    .q       (joystick),
    .changed (changed)
  );

  assign joy_clk  = joy_clk_q;
  assign joy_load = joy_load_q;
  assign valid    = valid_q;

endmodule
